// File: rtl/hashin_unpack.sv
// hashin_unpack: pulls framed 64-bit words out of the hashin FIFO,
// resynchronises on the frame marker, assembles the payload words into one
// wide block for the hash core and delivers it with a valid/ready handshake.
// The stop input aborts any frame in progress and drains the FIFO until
// stop_ack_unpack reports that the block is idle.

module hashin_unpack #(
    parameter logic [63:0] HDR_WORD      = 64'h8000000000000280,
    parameter int unsigned PAYLOAD_WORDS = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [63:0]                     hashin_fifo_dout,
    input  logic                            hashin_fifo_empty,
    output logic                            hashin_fifo_re,
    input  logic                            stop,
    output logic                            stop_ack_unpack,
    output logic [64*PAYLOAD_WORDS-1:0]     blk_data,
    output logic                            blk_valid,
    input  logic                            blk_ready,
    output logic [15:0]                     frame_err_cnt,
    output logic [31:0]                     blk_cnt
);

    localparam int unsigned      BLK_W   = 64 * PAYLOAD_WORDS;
    localparam int unsigned      CNT_W   = $clog2(PAYLOAD_WORDS + 1);
    localparam int unsigned      IDX_W   = $clog2(BLK_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PAYLOAD_WORDS);

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2,
        FLUSH   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]  rcv_cnt_q, rcv_cnt_d;
    logic [BLK_W-1:0]  blk_data_q, blk_data_d;
    logic              blk_valid_q, blk_valid_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [31:0]       blk_cnt_q, blk_cnt_d;
    logic              ack_q, ack_d;

    logic              re;
    logic              drained;
    logic [IDX_W-1:0]  wr_lsb;

    // The FIFO is drained when it reports empty and no read data is still due.
    assign drained = hashin_fifo_empty && !inflight_q;

    // Next-state, read-enable and datapath update logic.
    always_comb begin
        // NOTE: every _d starts as its _q, so no branch can leave a latch behind.
        state_d     = state_q;
        req_cnt_d   = req_cnt_q;
        rcv_cnt_d   = rcv_cnt_q;
        blk_data_d  = blk_data_q;
        blk_valid_d = blk_valid_q;
        err_cnt_d   = err_cnt_q;
        blk_cnt_d   = blk_cnt_q;
        re          = 1'b0;
        wr_lsb      = IDX_W'(BLK_W - 64) - IDX_W'({rcv_cnt_q, 6'd0});

        if (stop) begin
            // Abort wins over everything, including a same-cycle handshake.
            re          = !hashin_fifo_empty;
            state_d     = FLUSH;
            blk_valid_d = 1'b0;
            req_cnt_d   = '0;
            rcv_cnt_d   = '0;
        end else begin
            unique case (state_q)
                SYNC: begin
                    // One read at a time so every returned word is inspected.
                    re = !hashin_fifo_empty && !inflight_q;
                    if (inflight_q) begin
                        if (hashin_fifo_dout == HDR_WORD) begin
                            state_d   = COLLECT;
                            req_cnt_d = '0;
                            rcv_cnt_d = '0;
                        end else if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                    end
                end
                COLLECT: begin
                    re = !hashin_fifo_empty && (req_cnt_q < CNT_MAX);
                    if (re) begin
                        req_cnt_d = req_cnt_q + 1'b1;
                    end
                    if (inflight_q) begin
                        // Payload is opaque: stored without any marker compare.
                        blk_data_d[wr_lsb +: 64] = hashin_fifo_dout;
                        rcv_cnt_d = rcv_cnt_q + 1'b1;
                        if (rcv_cnt_d == CNT_MAX) begin
                            state_d     = PRESENT;
                            blk_valid_d = 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (blk_valid_q && blk_ready) begin
                        blk_valid_d = 1'b0;
                        blk_cnt_d   = blk_cnt_q + 32'd1;
                        state_d     = SYNC;
                    end
                end
                FLUSH: begin
                    re = !hashin_fifo_empty;
                    if (drained) begin
                        state_d = SYNC;
                    end
                end
                default: state_d = SYNC;
            endcase
        end

        inflight_d = re;
        ack_d      = ((state_q == FLUSH) || (state_q == SYNC)) && drained;
    end

    // Read enable follows the live empty flag so a burst stops on the exact
    // cycle the FIFO runs dry; it is forced low while reset is held.
    assign hashin_fifo_re = re && !rst;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SYNC;
            inflight_q  <= 1'b0;
            req_cnt_q   <= '0;
            rcv_cnt_q   <= '0;
            // NOTE: the wide block register is reset too, since blk_data must read zero in reset.
            blk_data_q  <= '0;
            blk_valid_q <= 1'b0;
            err_cnt_q   <= '0;
            blk_cnt_q   <= '0;
            ack_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            state_q     <= state_d;
            inflight_q  <= inflight_d;
            req_cnt_q   <= req_cnt_d;
            rcv_cnt_q   <= rcv_cnt_d;
            blk_data_q  <= blk_data_d;
            blk_valid_q <= blk_valid_d;
            err_cnt_q   <= err_cnt_d;
            blk_cnt_q   <= blk_cnt_d;
            ack_q       <= ack_d;
        end
    end

    assign blk_data        = blk_data_q;
    assign blk_valid       = blk_valid_q;
    assign frame_err_cnt   = err_cnt_q;
    assign blk_cnt         = blk_cnt_q;
    assign stop_ack_unpack = ack_q;

endmodule

// File: tb/tb_hashin_unpack.sv
// Directed bench for hashin_unpack: a standard-mode FIFO model feeds framed
// words, a monitor records delivered blocks and protocol violations, and one
// task per scenario compares results against hand-computed values.

module tb_hashin_unpack;

    localparam logic [63:0] HDR   = 64'h8000000000000280;
    localparam int          PW    = 10;
    localparam int          BW    = 64 * PW;
    localparam int          DEPTH = 66000;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   hashin_fifo_dout;
    logic          hashin_fifo_empty;
    logic          hashin_fifo_re;
    logic          stop;
    logic          stop_ack_unpack;
    logic [BW-1:0] blk_data;
    logic          blk_valid;
    logic          blk_ready;
    logic [15:0]   frame_err_cnt;
    logic [31:0]   blk_cnt;

    logic [63:0]   fifo_mem [DEPTH];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          empty_mask = 1'b0;

    int            n_checks = 0;
    int            n_fail = 0;
    int            re_empty_viol = 0;
    int            re_present_viol = 0;
    int            valid_cycles = 0;
    logic [BW-1:0] got_q [$];

    hashin_unpack dut (
        .clk               (clk),
        .rst               (rst),
        .hashin_fifo_dout  (hashin_fifo_dout),
        .hashin_fifo_empty (hashin_fifo_empty),
        .hashin_fifo_re    (hashin_fifo_re),
        .stop              (stop),
        .stop_ack_unpack   (stop_ack_unpack),
        .blk_data          (blk_data),
        .blk_valid         (blk_valid),
        .blk_ready         (blk_ready),
        .frame_err_cnt     (frame_err_cnt),
        .blk_cnt           (blk_cnt)
    );

    always #5 clk = ~clk;

    assign hashin_fifo_empty = (wr_ptr == rd_ptr) || empty_mask;

    // Standard-mode FIFO: data appears the cycle after the read enable.
    always @(posedge clk) begin
        if (hashin_fifo_re && (wr_ptr != rd_ptr)) begin
            hashin_fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr           <= rd_ptr + 1;
        end
    end

    // Protocol monitor and block scoreboard capture.
    always @(posedge clk) begin
        if (!rst) begin
            if (hashin_fifo_re && hashin_fifo_empty) re_empty_viol <= re_empty_viol + 1;
            if (hashin_fifo_re && blk_valid)         re_present_viol <= re_present_viol + 1;
            if (blk_valid)                           valid_cycles <= valid_cycles + 1;
            if (blk_valid && blk_ready)              got_q.push_back(blk_data);
        end
    end

    function automatic logic [BW-1:0] block_of(input logic [63:0] base);
        logic [BW-1:0] b;
        b = '0;
        for (int k = 0; k < PW; k++) begin
            b = {b[BW-65:0], base + 64'(k)};
        end
        return b;
    endfunction

    task automatic push_word(input logic [63:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic push_frame(input logic [63:0] base);
        push_word(HDR);
        for (int k = 0; k < PW; k++) push_word(base + 64'(k));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_blocks(input int n, input int budget, output bit ok);
        int c = 0;
        while ((got_q.size() < n) && (c < budget)) begin
            @(negedge clk);
            c++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic wait_drain_ack(input int budget, output bit ok);
        int c = 0;
        while (!((wr_ptr == rd_ptr) && stop_ack_unpack) && (c < budget)) begin
            @(negedge clk);
            c++;
        end
        ok = (wr_ptr == rd_ptr) && stop_ack_unpack;
    endtask

    task automatic test_reset();
        n_checks++; if (hashin_fifo_re !== 1'b0) begin n_fail++; $display("FAIL rst_re: got %b expected 0", hashin_fifo_re); end
        n_checks++; if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", blk_valid); end
        n_checks++; if (blk_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h expected 0", blk_data); end
        n_checks++; if (frame_err_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_err: got %0d expected 0", frame_err_cnt); end
        n_checks++; if (blk_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_blk_cnt: got %0d expected 0", blk_cnt); end
        n_checks++; if (stop_ack_unpack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b expected 0", stop_ack_unpack); end
        rst = 1'b0;
        tick(2);
        n_checks++; if (stop_ack_unpack !== 1'b1) begin n_fail++; $display("FAIL idle_ack: got %b expected 1", stop_ack_unpack); end
    endtask

    task automatic test_basic_frame();
        bit ok;
        logic [BW-1:0] b;
        blk_ready = 1'b1;
        push_frame(64'h0);
        wait_blocks(1, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: got %0d blocks expected 1", got_q.size()); end
        tick(30);
        b = got_q[0];
        n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL basic_count: got %0d handshakes expected 1", got_q.size()); end
        n_checks++; if (b[BW-1 -: 64] !== 64'h0) begin n_fail++; $display("FAIL basic_first_word: got %h expected 0", b[BW-1 -: 64]); end
        n_checks++; if (b[63:0] !== 64'h9) begin n_fail++; $display("FAIL basic_last_word: got %h expected 9", b[63:0]); end
        n_checks++; if (b !== block_of(64'h0)) begin n_fail++; $display("FAIL basic_block: got %h expected %h", b, block_of(64'h0)); end
        n_checks++; if (blk_cnt !== 32'd1) begin n_fail++; $display("FAIL basic_blk_cnt: got %0d expected 1", blk_cnt); end
        n_checks++; if (frame_err_cnt !== 16'd0) begin n_fail++; $display("FAIL basic_err: got %0d expected 0", frame_err_cnt); end
        n_checks++; if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_clear: got %b expected 0", blk_valid); end
    endtask

    task automatic test_junk_then_frame();
        bit ok;
        for (int i = 0; i < 3; i++) push_word(64'hDEAD_BEEF_0000_0000 + 64'(i));
        push_frame(64'h100);
        wait_blocks(2, 300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL junk_timeout: got %0d blocks expected 2", got_q.size()); end
        n_checks++; if (got_q[1] !== block_of(64'h100)) begin n_fail++; $display("FAIL junk_block: got %h expected %h", got_q[1], block_of(64'h100)); end
        n_checks++; if (frame_err_cnt !== 16'd3) begin n_fail++; $display("FAIL junk_err: got %0d expected 3", frame_err_cnt); end
        n_checks++; if (blk_cnt !== 32'd2) begin n_fail++; $display("FAIL junk_blk_cnt: got %0d expected 2", blk_cnt); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int c = 0;
        int unstable = 0;
        int dropped = 0;
        int rd_snap;
        logic [BW-1:0] snap;
        blk_ready = 1'b0;
        push_frame(64'h200);
        push_frame(64'h300);
        while (!blk_valid && (c < 200)) begin
            @(negedge clk);
            c++;
        end
        n_checks++; if (blk_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_timeout: got %b expected 1", blk_valid); end
        snap    = blk_data;
        rd_snap = rd_ptr;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (blk_data !== snap) unstable++;
            if (blk_valid !== 1'b1) dropped++;
        end
        n_checks++; if (snap !== block_of(64'h200)) begin n_fail++; $display("FAIL bp_first_block: got %h expected %h", snap, block_of(64'h200)); end
        n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes expected 0", unstable); end
        n_checks++; if (dropped !== 0) begin n_fail++; $display("FAIL bp_valid_hold: got %0d low cycles expected 0", dropped); end
        n_checks++; if (rd_ptr !== rd_snap) begin n_fail++; $display("FAIL bp_no_reads: got %0d reads expected 0", rd_ptr - rd_snap); end
        blk_ready = 1'b1;
        wait_blocks(4, 300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got %0d blocks expected 4", got_q.size()); end
        n_checks++; if (got_q[2] !== block_of(64'h200)) begin n_fail++; $display("FAIL bp_block_a: got %h expected %h", got_q[2], block_of(64'h200)); end
        n_checks++; if (got_q[3] !== block_of(64'h300)) begin n_fail++; $display("FAIL bp_block_b: got %h expected %h", got_q[3], block_of(64'h300)); end
        n_checks++; if (blk_cnt !== 32'd4) begin n_fail++; $display("FAIL bp_blk_cnt: got %0d expected 4", blk_cnt); end
    endtask

    task automatic test_stop_flush();
        bit ok;
        int vc0;
        vc0 = valid_cycles;
        push_word(HDR);
        for (int k = 0; k < 4; k++) push_word(64'h400 + 64'(k));
        tick(20);
        for (int k = 4; k < 10; k++) push_word(64'h400 + 64'(k));
        stop = 1'b1;
        wait_drain_ack(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stop_drain_timeout: got %0d words left expected 0", wr_ptr - rd_ptr); end
        tick(3);
        n_checks++; if (stop_ack_unpack !== 1'b1) begin n_fail++; $display("FAIL stop_ack: got %b expected 1", stop_ack_unpack); end
        n_checks++; if (valid_cycles !== vc0) begin n_fail++; $display("FAIL stop_no_valid: got %0d valid cycles expected 0", valid_cycles - vc0); end
        n_checks++; if (blk_cnt !== 32'd4) begin n_fail++; $display("FAIL stop_blk_cnt: got %0d expected 4", blk_cnt); end
        n_checks++; if (frame_err_cnt !== 16'd3) begin n_fail++; $display("FAIL stop_err: got %0d expected 3", frame_err_cnt); end
        stop = 1'b0;
        tick(3);
        n_checks++; if (stop_ack_unpack !== 1'b1) begin n_fail++; $display("FAIL stop_idle_ack: got %b expected 1", stop_ack_unpack); end
        push_frame(64'h500);
        wait_blocks(5, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stop_next_timeout: got %0d blocks expected 5", got_q.size()); end
        n_checks++; if (got_q[4] !== block_of(64'h500)) begin n_fail++; $display("FAIL stop_next_block: got %h expected %h", got_q[4], block_of(64'h500)); end
        n_checks++; if (blk_cnt !== 32'd5) begin n_fail++; $display("FAIL stop_next_cnt: got %0d expected 5", blk_cnt); end
    endtask

    task automatic test_empty_toggle();
        int c = 0;
        push_frame(64'h600);
        while ((got_q.size() < 6) && (c < 400)) begin
            @(negedge clk);
            empty_mask = 1'($urandom_range(0, 1));
            c++;
        end
        empty_mask = 1'b0;
        n_checks++; if (got_q.size() < 6) begin n_fail++; $display("FAIL toggle_timeout: got %0d blocks expected 6", got_q.size()); end
        n_checks++; if (got_q[5] !== block_of(64'h600)) begin n_fail++; $display("FAIL toggle_block: got %h expected %h", got_q[5], block_of(64'h600)); end
        n_checks++; if (re_empty_viol !== 0) begin n_fail++; $display("FAIL toggle_re_empty: got %0d violations expected 0", re_empty_viol); end
        n_checks++; if (blk_cnt !== 32'd6) begin n_fail++; $display("FAIL toggle_blk_cnt: got %0d expected 6", blk_cnt); end
    endtask

    task automatic test_saturation_and_reset();
        bit ok;
        for (int i = 0; i < 65540; i++) push_word(64'h0BAD_0000_0000_0000 + 64'(i));
        wait_drain_ack(140000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL sat_timeout: got %0d words left expected 0", wr_ptr - rd_ptr); end
        n_checks++; if (frame_err_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_err: got %h expected ffff", frame_err_cnt); end
        push_word(HDR);
        for (int k = 0; k < 5; k++) push_word(64'h700 + 64'(k));
        tick(20);
        for (int k = 0; k < 3; k++) push_word(64'h0BAD_0000_0001_0000 + 64'(k));
        rst = 1'b1;
        tick(2);
        n_checks++; if (hashin_fifo_re !== 1'b0) begin n_fail++; $display("FAIL mid_rst_re: got %b expected 0", hashin_fifo_re); end
        n_checks++; if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b expected 0", blk_valid); end
        n_checks++; if (blk_data !== '0) begin n_fail++; $display("FAIL mid_rst_data: got %h expected 0", blk_data); end
        n_checks++; if (frame_err_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst_err: got %0d expected 0", frame_err_cnt); end
        n_checks++; if (blk_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_rst_blk_cnt: got %0d expected 0", blk_cnt); end
        n_checks++; if (stop_ack_unpack !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ack: got %b expected 0", stop_ack_unpack); end
        n_checks++; if ((wr_ptr - rd_ptr) !== 3) begin n_fail++; $display("FAIL mid_rst_no_flush: got %0d words left expected 3", wr_ptr - rd_ptr); end
        rst = 1'b0;
        wait_drain_ack(100, ok);
        n_checks++; if (frame_err_cnt !== 16'd3) begin n_fail++; $display("FAIL post_rst_err: got %0d expected 3", frame_err_cnt); end
        push_frame(64'h900);
        wait_blocks(7, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL post_rst_timeout: got %0d blocks expected 7", got_q.size()); end
        n_checks++; if (got_q[6] !== block_of(64'h900)) begin n_fail++; $display("FAIL post_rst_block: got %h expected %h", got_q[6], block_of(64'h900)); end
        n_checks++; if (blk_cnt !== 32'd1) begin n_fail++; $display("FAIL post_rst_blk_cnt: got %0d expected 1", blk_cnt); end
    endtask

    initial begin
        rst       = 1'b1;
        stop      = 1'b0;
        blk_ready = 1'b0;
        tick(3);
        test_reset();
        test_basic_frame();
        test_junk_then_frame();
        test_back_to_back();
        test_stop_flush();
        test_empty_toggle();
        test_saturation_and_reset();
        n_checks++; if (re_empty_viol !== 0) begin n_fail++; $display("FAIL re_while_empty: got %0d violations expected 0", re_empty_viol); end
        n_checks++; if (re_present_viol !== 0) begin n_fail++; $display("FAIL re_while_valid: got %0d violations expected 0", re_present_viol); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
